// File: rtl/serial_adder_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller:
//     - FSM state encoding (state_t)
//     - WIDTH legality limits and the SERIAL_ADDER_WIDTH_OK(w) check macro
//   No ports; imported by serial_adder_ctrl with import serial_adder_ctrl_pkg::*.
// ----------------------------------------------------------------------------
`ifndef SERIAL_ADDER_CTRL_PKG_SV
`define SERIAL_ADDER_CTRL_PKG_SV

// Evaluates true when w is a supported operand width.
`define SERIAL_ADDER_WIDTH_OK(w) (((w) >= 1) && ((w) <= 32))

package serial_adder_ctrl_pkg;

    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`endif

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Single-bit combinational full adder; the shared datapath cell that the
//   serial controller sequences once per bit.
//   Ports:
//     a, b  in   operand bits
//     cin   in   carry in
//     sum   out  a ^ b ^ cin
//     cout  out  majority(a, b, cin)
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder controller. Adds two WIDTH-bit operands plus carry-in by
//   running one shared full_adder cell for WIDTH cycles, LSB first.
//   Handshake: start is accepted in IDLE or DONE; busy is high for the WIDTH
//   RUN cycles; done pulses for one cycle when sum/cout become valid.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   begin an addition (ignored while busy)
//     a, b   in   WIDTH-bit operands, captured on accepted start
//     cin    in   carry-in, captured on accepted start
//     busy   out  high while the serial add is running
//     done   out  one-cycle pulse when the result is valid
//     sum    out  WIDTH-bit result, held until the next result
//     cout   out  final carry-out, same validity as sum
// ----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    generate
        if (!`SERIAL_ADDER_WIDTH_OK(WIDTH)) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of supported range 1..32");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_nxt;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_carry)
    );

    // Result bits enter at the MSB and move down, so after WIDTH shifts the
    // first (LSB) result bit has reached position 0. A 1-bit result has no
    // lower part to shift, hence the separate branch.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_nxt = fa_sum;
        end else begin : g_sum_wn
            assign sum_nxt = {fa_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                // DONE behaves like IDLE for start so operations can run
                // back-to-back with no idle gap.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    carry  <= fa_carry;
                    sum_sh <= sum_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    // Final bit: publish the completed result directly so the
                    // outputs are valid in the same cycle done is high.
                    if (cnt == LAST_BIT) begin
                        sum   <= sum_nxt;
                        cout  <= fa_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One 8-bit addition from IDLE/DONE. Reference result is plain integer
    // addition; operands are scrambled during RUN to confirm they are ignored.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input bit poke, input string tag);
        logic [8:0] exp;
        int lat;
        int bcnt;
        exp = {1'b0, ta} + {1'b0, tb_} + {8'b0, tc};
        start8 = 1'b1; a8 = ta; b8 = tb_; cin8 = tc;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        bcnt = busy8 ? 1 : 0;
        lat  = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (poke && lat == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; end
            if (poke && lat == 4) start8 = 1'b0;
            if (done8) break;
            if (busy8) bcnt++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd8);
        chk({tag, "_busy_at_done"}, 64'(busy8), 64'd0);
        chk({tag, "_result"}, {55'b0, cout8, sum8}, {55'b0, exp});
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done8), 64'd0);
        chk({tag, "_hold"}, {55'b0, cout8, sum8}, {55'b0, exp});
    endtask

    task automatic op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
        logic [3:0] exp;
        int lat;
        exp = {1'b0, ta} + {1'b0, tb_} + {3'b0, tc};
        start3 = 1'b1; a3 = ta; b3 = tb_; cin3 = tc;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done3) break;
        end
        chk("w3_latency", 64'(lat), 64'd3);
        chk("w3_result", {60'b0, cout3, sum3}, {60'b0, exp});
    endtask

    initial begin
        int lat;
        rst_n  = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs8", {52'b0, busy8, done8, cout8, sum8}, 64'd0);
        chk("reset_outputs3", {57'b0, busy3, done3, cout3, sum3}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        op8(8'h05, 8'h03, 1'b0, 1'b0, "add_05_03");
        op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01");
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
        op8(8'h05, 8'h03, 1'b0, 1'b1, "poke_midrun");

        // Random operands
        for (int i = 0; i < 8; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random");
        end

        // start held high: back-to-back operations spaced WIDTH+1 apart
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            lat = 0;
            while (lat < 20) begin
                @(posedge clk); #1;
                lat++;
                if (lat == 1) chk("held_busy_no_idle", 64'(busy8), 64'd1);
                if (done8) break;
            end
            chk("held_spacing", 64'(lat), (k == 0) ? 64'd8 : 64'd9);
            chk("held_result", {55'b0, cout8, sum8}, 64'h30);
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("held_release_idle", {62'b0, busy8, done8}, 64'd0);

        // Reset during RUN aborts and clears outputs immediately
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", {52'b0, busy8, done8, cout8, sum8}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 7) chk("reset_no_done", {62'b0, busy8, done8}, 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h0A, 8'h05, 1'b0, 1'b0, "after_reset");

        // WIDTH=3 exhaustive
        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op3(3'(ia), 3'(ib), 1'(ic));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: sequences one shared 1-bit full_adder cell over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in.
- Holds operand/result shift registers and a carry flip-flop, and runs a start/busy/done handshake.
- Sits between a register-level requester and the existing full_adder datapath cell, trading latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; valid from the done cycle until the next accepted start.
- cout  output  1  final carry-out; same validity as sum.

Behaviour:
- Reset (async assert, sync-safe deassert by the user): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry flip-flop and counter are cleared.
- States:
  - IDLE: start=1 → RUN. Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0.
  - RUN: each cycle, the full_adder takes (a_sh[0], b_sh[0], carry).
    - carry<=fa_carry.
    - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]} (LSB result enters at MSB, shifts down).
    - a_sh and b_sh shift right by 1.
    - cnt<=cnt+1.
    - When cnt==WIDTH-1 the update completes the final bit and state → DONE.
  - DONE: done=1 for exactly this cycle. sum=sum_sh, cout=carry.
    - start=1 → RUN with a new load, as in IDLE (back-to-back operation).
    - Otherwise → IDLE.
- Latency: start accepted at edge N; done high during the cycle after edge N+WIDTH; total WIDTH+1 cycles start-to-done.
- busy=1 exactly in RUN (WIDTH cycles); start is ignored while busy, and a/b/cin changes during RUN have no effect.
- Outputs sum and cout are registered. They hold their last result through IDLE and change only on the DONE transition; they are not cleared by a new start.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts one cycle; start-to-done is 2 cycles.
- Reset during RUN: operation is aborted and all outputs return to reset values immediately; no done pulse.
- start held high continuously: one operation every WIDTH+1 cycles, done pulses spaced WIDTH+1 apart.

Decomposition:
- Shared package/header holds the state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the WIDTH legality check macro.
- Instantiate the existing full_adder as the sole sub-module (one instance, named u_fa). The FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, cin=0, start pulse → busy high 8 cycles; done at start+9 cycles; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start pulsed mid-RUN with a=0x11, b=0x22 → ignored; original result 0x05+0x03=0x08 is delivered unchanged; busy stays high exactly 8 cycles.
- start held high continuously with a=0x10, b=0x20 → done pulses every 9 cycles, sum=0x30 each time; no IDLE cycle between operations.
- rst_n dropped 4 cycles into RUN → busy, done, sum and cout go to 0 asynchronously. After release, the next start with a=0x0A, b=0x05 gives sum=0x0F correctly.
- WIDTH=3 instance, exhaustive: all 128 (a,b,cin) combinations → {cout,sum}==a+b+cin for each, with the done pulse 4 cycles after start.
